// File: rtl/fetch_seq_ctrl.sv
// Multi-cycle fetch/PC sequencer: req/gnt/rvalid fetch, instruction hold, next-PC and fault capture.
// Optional macro FETCH_TIMEOUT_EN adds a WAIT-state timeout that raises fault cause 10.
//
// state | meaning
// FETCH | imem_req high at pc, waiting for gnt
// WAIT  | request accepted, waiting for rvalid
// EXEC  | ins valid; advance pc when stall is low
// HALT  | fault captured, frozen until rst
module fetch_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ins,
    output logic        ins_valid,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_val,
    input  logic        br_taken,
    input  logic        stall,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        retire,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_pc
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [31:0] INS_NOP     = 32'h0000_0013;
    localparam logic [6:0]  OP_JAL      = 7'h6f;
    localparam logic [6:0]  OP_JALR     = 7'h67;
    localparam logic [6:0]  OP_BRANCH   = 7'h63;
    localparam logic [1:0]  CAUSE_ALIGN = 2'b01;

    generate
        if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
            $error("fetch_seq_ctrl: TIMEOUT must be in 1..255");
        end
    endgenerate

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ins_q, ins_d;
    logic        fault_q, fault_d;
    logic [1:0]  fault_cause_q, fault_cause_d;
    logic [31:0] fault_pc_q, fault_pc_d;
    logic [31:0] target;
    logic [31:0] seq_pc;
    logic        retire_c;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);
    localparam logic [1:0] CAUSE_TMO = 2'b10;
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
`endif

    assign seq_pc = pc_q + 32'd4;

    always_comb begin
        target = seq_pc;
        case (ins_q[6:0])
            OP_JAL:    target = pc_q + imm;
            OP_JALR:   target = (rs1_val + imm) & ~32'd1;
            OP_BRANCH: target = br_taken ? (pc_q + imm) : seq_pc;
            default:   target = seq_pc;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ins_d         = ins_q;
        fault_d       = fault_q;
        fault_cause_d = fault_cause_q;
        fault_pc_d    = fault_pc_q;
        retire_c      = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
`endif
        case (state_q)
            S_FETCH: begin
                if (imem_gnt) begin
                    state_d = S_WAIT;
`ifdef FETCH_TIMEOUT_EN
                    tmo_cnt_d = 8'd0;
`endif
                end
            end
            S_WAIT: begin
                // rvalid wins over a timeout reached in the same cycle
                if (imem_rvalid) begin
                    ins_d   = imem_rdata;
                    state_d = S_EXEC;
                end
`ifdef FETCH_TIMEOUT_EN
                else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                    if (tmo_cnt_d == TMO_LIMIT) begin
                        state_d       = S_HALT;
                        fault_d       = 1'b1;
                        fault_cause_d = CAUSE_TMO;
                        fault_pc_d    = pc_q;
                    end
                end
`endif
            end
            S_EXEC: begin
                if (!stall) begin
                    if (target[1:0] != 2'b00) begin
                        state_d       = S_HALT;
                        fault_d       = 1'b1;
                        fault_cause_d = CAUSE_ALIGN;
                        fault_pc_d    = target;
                    end else begin
                        pc_d     = target;
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            ins_q         <= INS_NOP;
            fault_q       <= 1'b0;
            fault_cause_q <= 2'b00;
            fault_pc_q    <= 32'd0;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt_q     <= 8'd0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ins_q         <= ins_d;
            fault_q       <= fault_d;
            fault_cause_q <= fault_cause_d;
            fault_pc_q    <= fault_pc_d;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
`endif
        end
    end

    assign imem_req    = (state_q == S_FETCH) && !rst;
    assign imem_addr   = pc_q;
    assign ins         = ins_q;
    assign ins_valid   = (state_q == S_EXEC);
    assign pc          = pc_q;
    assign pc_plus4    = seq_pc;
    assign retire      = retire_c && !rst;
    assign fault       = fault_q;
    assign fault_cause = fault_cause_q;
    assign fault_pc    = fault_pc_q;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Self-checking bench for fetch_seq_ctrl: scripted memory responder with a queue of expected fetch addresses.
module tb_fetch_seq_ctrl;

    localparam logic [31:0] RST_PC   = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] ADDI     = 32'h0010_0093;
    localparam logic [31:0] JAL      = 32'h0100_006f;
    localparam logic [31:0] BEQ      = 32'hfe00_0ce3;
    localparam logic [31:0] JALR     = 32'h0010_8067;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] ins;
    logic        ins_valid;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic        br_taken;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        retire;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] fault_pc;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    logic [31:0] exp_q[$];

    fetch_seq_ctrl #(.RESET_PC(RST_PC), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .ins(ins), .ins_valid(ins_valid), .imm(imm), .rs1_val(rs1_val),
        .br_taken(br_taken), .stall(stall), .pc(pc), .pc_plus4(pc_plus4),
        .retire(retire), .fault(fault), .fault_cause(fault_cause), .fault_pc(fault_pc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // Waits for a request, grants it, then returns word one cycle later; ends on the EXEC-cycle negedge.
    task automatic serve_fetch(input logic [31:0] word, output logic [31:0] addr,
                               output logic ok, output logic valid_in_wait);
        ok = 1'b0;
        addr = 32'hxxxx_xxxx;
        valid_in_wait = 1'bx;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (imem_req) ok = 1'b1;
            else @(negedge clk);
        end
        if (ok) begin
            addr = imem_addr;
            imem_gnt = 1'b1;
            @(negedge clk);
            imem_gnt = 1'b0;
            valid_in_wait = ins_valid;
            imem_rvalid = 1'b1;
            imem_rdata = word;
            @(negedge clk);
            imem_rvalid = 1'b0;
            imem_rdata = 32'h0;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        imm = 32'h0;
        rs1_val = 32'h0;
        br_taken = 1'b0;
        stall = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0h want 0", imem_req); end
        n_chk++; if (pc !== RST_PC) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, RST_PC); end
        n_chk++; if (ins !== NOP) begin n_fail++; $display("FAIL reset_ins: got %h want %h", ins, NOP); end
        n_chk++; if ({ins_valid, retire, fault, fault_cause} !== 5'b0) begin n_fail++;
            $display("FAIL reset_flags: got %b want 00000", {ins_valid, retire, fault, fault_cause}); end
        n_chk++; if (fault_pc !== 32'h0) begin n_fail++; $display("FAIL reset_fault_pc: got %h want 0", fault_pc); end
        rst = 1'b0;
    endtask

    task automatic test_straight_line();
        logic [31:0] a, e;
        logic ok, vw;
        int last_ret;
        last_ret = -1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        for (int i = 0; i < 4; i++) begin
            serve_fetch(ADDI, a, ok, vw);
            e = exp_q.pop_front();
            n_chk++; if (!ok || a !== e) begin n_fail++; $display("FAIL seq_addr[%0d]: got %h want %h", i, a, e); end
            n_chk++; if (vw !== 1'b0) begin n_fail++; $display("FAIL seq_valid_wait[%0d]: got %b want 0", i, vw); end
            n_chk++; if (ins_valid !== 1'b1 || ins !== ADDI || pc !== e) begin n_fail++;
                $display("FAIL seq_exec[%0d]: got v=%b ins=%h pc=%h want v=1 ins=%h pc=%h", i, ins_valid, ins, pc, ADDI, e); end
            n_chk++; if (retire !== 1'b1) begin n_fail++; $display("FAIL seq_retire[%0d]: got %b want 1", i, retire); end
            if (last_ret >= 0) begin
                n_chk++; if (cyc - last_ret != 3) begin n_fail++;
                    $display("FAIL seq_period[%0d]: got %0d want 3", i, cyc - last_ret); end
            end
            last_ret = cyc;
            @(negedge clk);
            n_chk++; if (retire !== 1'b0 || ins_valid !== 1'b0) begin n_fail++;
                $display("FAIL seq_after[%0d]: got ret=%b v=%b want 0 0", i, retire, ins_valid); end
        end
        exp_q.push_back(32'h10);
    endtask

    task automatic test_jal();
        logic [31:0] a, e;
        logic ok, vw;
        imm = 32'h10;
        serve_fetch(JAL, a, ok, vw);
        e = exp_q.pop_front();
        n_chk++; if (!ok || a !== e) begin n_fail++; $display("FAIL jal_addr: got %h want %h", a, e); end
        n_chk++; if (pc_plus4 !== 32'h14) begin n_fail++; $display("FAIL jal_pc_plus4: got %h want 14", pc_plus4); end
        n_chk++; if (retire !== 1'b1) begin n_fail++; $display("FAIL jal_retire: got %b want 1", retire); end
        exp_q.push_back(32'h20);
        @(negedge clk);
        n_chk++; if (retire !== 1'b0) begin n_fail++; $display("FAIL jal_retire_once: got %b want 0", retire); end
        e = exp_q.pop_front();
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== e) begin n_fail++;
            $display("FAIL jal_next_addr: got req=%b addr=%h want 1 %h", imem_req, imem_addr, e); end
        exp_q.push_back(32'h20);
    endtask

    task automatic test_branch();
        logic [31:0] a, e;
        logic ok, vw;
        imm = 32'h20;
        serve_fetch(JAL, a, ok, vw);
        e = exp_q.pop_front();
        n_chk++; if (!ok || a !== e) begin n_fail++; $display("FAIL br_hop_addr: got %h want %h", a, e); end
        exp_q.push_back(32'h40);
        @(negedge clk);
        imm = 32'hFFFF_FFF8;
        br_taken = 1'b1;
        serve_fetch(BEQ, a, ok, vw);
        e = exp_q.pop_front();
        n_chk++; if (!ok || a !== e) begin n_fail++; $display("FAIL br_taken_pc: got %h want %h", a, e); end
        exp_q.push_back(32'h38);
        @(negedge clk);
        br_taken = 1'b0;
        imm = 32'h8;
        serve_fetch(JAL, a, ok, vw);
        e = exp_q.pop_front();
        n_chk++; if (!ok || a !== e) begin n_fail++; $display("FAIL br_taken_target: got %h want %h", a, e); end
        exp_q.push_back(32'h40);
        @(negedge clk);
        imm = 32'hFFFF_FFF8;
        br_taken = 1'b0;
        serve_fetch(BEQ, a, ok, vw);
        e = exp_q.pop_front();
        n_chk++; if (!ok || a !== e) begin n_fail++; $display("FAIL br_nt_pc: got %h want %h", a, e); end
        exp_q.push_back(32'h44);
        @(negedge clk);
    endtask

    task automatic test_stall();
        logic [31:0] a, e;
        logic ok, vw;
        stall = 1'b1;
        br_taken = 1'b1;
        serve_fetch(ADDI, a, ok, vw);
        e = exp_q.pop_front();
        n_chk++; if (!ok || a !== e) begin n_fail++; $display("FAIL stall_addr: got %h want %h", a, e); end
        for (int i = 0; i < 5; i++) begin
            n_chk++; if (ins !== ADDI || pc !== e || ins_valid !== 1'b1 || retire !== 1'b0) begin n_fail++;
                $display("FAIL stall_hold[%0d]: got ins=%h pc=%h v=%b ret=%b want %h %h 1 0", i, ins, pc, ins_valid, retire, ADDI, e); end
            if (i < 4) @(negedge clk);
        end
        @(negedge clk);
        stall = 1'b0;
        #1;
        n_chk++; if (retire !== 1'b1) begin n_fail++; $display("FAIL stall_release_retire: got %b want 1", retire); end
        exp_q.push_back(32'h48);
        @(negedge clk);
        br_taken = 1'b0;
        e = exp_q.pop_front();
        n_chk++; if (imem_addr !== e || imem_req !== 1'b1) begin n_fail++;
            $display("FAIL stall_next_addr: got req=%b addr=%h want 1 %h", imem_req, imem_addr, e); end
        exp_q.push_back(32'h48);
    endtask

    task automatic test_jalr_misaligned();
        logic [31:0] a, e;
        logic ok, vw;
        rs1_val = 32'h101;
        imm = 32'h1;
        serve_fetch(JALR, a, ok, vw);
        e = exp_q.pop_front();
        n_chk++; if (!ok || a !== e) begin n_fail++; $display("FAIL jalr_addr: got %h want %h", a, e); end
        n_chk++; if (retire !== 1'b0) begin n_fail++; $display("FAIL jalr_no_retire: got %b want 0", retire); end
        @(negedge clk);
        rs1_val = 32'h0;
        imm = 32'h3;
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (fault !== 1'b1 || fault_cause !== 2'b01 || fault_pc !== 32'h102) begin n_fail++;
                $display("FAIL jalr_fault[%0d]: got f=%b c=%b pc=%h want 1 01 102", i, fault, fault_cause, fault_pc); end
            n_chk++; if (imem_req !== 1'b0 || retire !== 1'b0 || pc !== e || ins_valid !== 1'b0) begin n_fail++;
                $display("FAIL jalr_halt[%0d]: got req=%b ret=%b pc=%h v=%b want 0 0 %h 0", i, imem_req, retire, pc, ins_valid, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] a, e;
        logic ok, vw;
        apply_reset();
        rst = 1'b0;
        imem_gnt = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hBAD0_0001;
        @(negedge clk);
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        n_chk++; if (ins_valid !== 1'b0 || ins !== NOP) begin n_fail++;
            $display("FAIL gnt_rvalid_same_cycle: got v=%b ins=%h want 0 %h", ins_valid, ins, NOP); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_chk++; if (imem_req !== 1'b0 || pc !== RST_PC) begin n_fail++;
            $display("FAIL midwait_rst: got req=%b pc=%h want 0 %h", imem_req, pc, RST_PC); end
        rst = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rvalid = 1'b0;
        n_chk++; if (imem_req !== 1'b1 || imem_addr !== RST_PC || ins_valid !== 1'b0 || ins !== NOP) begin n_fail++;
            $display("FAIL late_rvalid: got req=%b addr=%h v=%b ins=%h want 1 %h 0 %h", imem_req, imem_addr, ins_valid, ins, RST_PC, NOP); end
        exp_q.push_back(RST_PC);
        serve_fetch(ADDI, a, ok, vw);
        e = exp_q.pop_front();
        n_chk++; if (!ok || a !== e || ins !== ADDI || ins_valid !== 1'b1) begin n_fail++;
            $display("FAIL post_rst_fetch: got addr=%h ins=%h v=%b want %h %h 1", a, ins, ins_valid, e, ADDI); end
    endtask

    task automatic test_timeout();
        apply_reset();
        rst = 1'b0;
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        repeat (3) @(negedge clk);
        n_chk++; if (fault !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b want 0", fault); end
        @(negedge clk);
        n_chk++; if (fault !== 1'b1 || fault_cause !== 2'b10 || fault_pc !== RST_PC || imem_req !== 1'b0) begin n_fail++;
            $display("FAIL tmo_fault: got f=%b c=%b pc=%h req=%b want 1 10 %h 0", fault, fault_cause, fault_pc, imem_req, RST_PC); end
        apply_reset();
        rst = 1'b0;
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        repeat (3) @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata = ADDI;
        @(negedge clk);
        imem_rvalid = 1'b0;
        n_chk++; if (fault !== 1'b0 || ins_valid !== 1'b1 || ins !== ADDI) begin n_fail++;
            $display("FAIL tmo_rvalid_at_limit: got f=%b v=%b ins=%h want 0 1 %h", fault, ins_valid, ins, ADDI); end
`else
        repeat (300) @(negedge clk);
        n_chk++; if (fault !== 1'b0 || fault_cause !== 2'b00 || ins_valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++;
            $display("FAIL no_tmo_wait: got f=%b c=%b v=%b req=%b want 0 00 0 0", fault, fault_cause, ins_valid, imem_req); end
        imem_rvalid = 1'b1;
        imem_rdata = ADDI;
        @(negedge clk);
        imem_rvalid = 1'b0;
        n_chk++; if (ins_valid !== 1'b1 || ins !== ADDI) begin n_fail++;
            $display("FAIL no_tmo_late_data: got v=%b ins=%h want 1 %h", ins_valid, ins, ADDI); end
`endif
    endtask

    initial begin
        test_reset();
        test_straight_line();
        test_jal();
        test_branch();
        test_stall();
        test_jalr_misaligned();
        test_reset_mid_wait();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_seq_ctrl.md
Name: fetch_seq_ctrl

Overview:
- Multi-cycle fetch/PC sequencer for the RISC-V core.
- Issues instruction-memory requests over a req/gnt/rvalid handshake and holds the fetched instruction for the decoder and immediate extender.
- Computes the next PC from the extended immediate, rs1 and the branch outcome, and flags misaligned targets and fetch timeouts.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- TIMEOUT, 255, maximum cycles spent in WAIT before a fetch fault. Used only when FETCH_TIMEOUT_EN is defined; legal range 1..255.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address.
- imem_gnt  in  1  memory accepted the request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  read data.
- ins  out  32  held instruction, to decoder and extender.
- ins_valid  out  1  ins is valid for execution.
- imm  in  32  extended immediate for ins, from the extender.
- rs1_val  in  32  register rs1 value, used for JALR.
- br_taken  in  1  branch compare result; sampled only in EXEC.
- stall  in  1  datapath busy; holds EXEC.
- pc  out  32  PC of ins.
- pc_plus4  out  32  pc+4, used as the link value.
- retire  out  1  one-cycle pulse when ins completes.
- fault  out  1  sticky fault flag.
- fault_cause  out  2  01 = misaligned target, 10 = fetch timeout.
- fault_pc  out  32  offending target, or the fetch address on timeout.

Behaviour:
- States: FETCH, WAIT, EXEC, HALT. Reset state is FETCH.
- Reset values:
  - pc = RESET_PC; ins = 32'h0000_0013 (NOP).
  - ins_valid = 0, retire = 0, fault = 0, fault_cause = 0, fault_pc = 0.
  - Timeout counter = 0.
  - imem_req is 0 in the reset cycle.
- Output decoding:
  - imem_req = (state == FETCH) && !rst.
  - imem_addr = pc.
  - ins_valid = (state == EXEC).
  - pc_plus4 = pc + 4, combinational.
- FETCH:
  - req and addr stay stable until gnt.
  - On gnt, go to WAIT and clear the timeout counter.
- WAIT:
  - On rvalid, capture ins <= imem_rdata and go to EXEC.
  - rvalid outside WAIT is ignored, including rvalid in the same cycle as gnt.
  - Minimum instruction period is 3 cycles: gnt, then rvalid, then an EXEC with no stall.
- EXEC:
  - While stall = 1, hold state; ins, pc and ins_valid are held and no retire is issued.
  - When stall = 0, compute target from ins[6:0]:
    - 7'h6f (JAL): pc + imm.
    - 7'h67 (JALR): (rs1_val + imm) & ~1.
    - 7'h63 (branch): br_taken ? pc + imm : pc + 4.
    - Any other opcode: pc + 4.
  - All arithmetic is modulo 2^32; wrap-around from 0xFFFF_FFFC to 0 is legal.
  - If target[1:0] != 0:
    - Go to HALT with fault = 1, fault_cause = 01, fault_pc = target.
    - pc is unchanged and retire is not pulsed.
  - Otherwise: pc <= target, retire = 1 for one cycle, go to FETCH.
- HALT:
  - imem_req = 0 and all fault outputs are frozen.
  - Only rst exits HALT.
- rst is asserted at any time, including mid-WAIT with a request outstanding:
  - Restore all reset values and return to FETCH at RESET_PC.
  - A late rvalid from the abandoned fetch arrives while in FETCH and is therefore ignored.
- rst has priority over every other event in the same cycle.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - The WAIT counter increments each cycle without rvalid.
  - When the count reaches TIMEOUT, go to HALT with fault_cause = 10 and fault_pc = pc.
  - If rvalid arrives in the same cycle the count reaches TIMEOUT, the data is accepted and no fault is raised.
- Undefined:
  - No counter is built; WAIT waits indefinitely.
  - Cause 10 is never produced.

Test Plan:
1. Straight-line code. Release rst; memory gives gnt immediately and rvalid one cycle later, returning addi words.
   -> Fetch addresses 0x0, 0x4, 0x8; retire every 3 cycles; ins_valid high only in EXEC.
2. JAL. ins = 0x0100006f at pc 0x10 with imm = 0x10.
   -> pc_plus4 = 0x14; next imem_addr = 0x20; retire pulses once.
3. Branch. beq at pc 0x40 with imm = 0xFFFF_FFF8.
   -> br_taken = 1 gives next fetch at 0x38; br_taken = 0 gives 0x44.
4. JALR misaligned. rs1_val = 0x101, imm = 0x1, so target = 0x102.
   -> fault = 1, fault_cause = 01, fault_pc = 0x102, no retire, imem_req stays 0 until rst.
5. Stall. Hold stall = 1 for 5 EXEC cycles.
   -> ins, pc and ins_valid are held; retire pulses in the cycle stall drops.
6. Timeout and mid-fetch reset. With FETCH_TIMEOUT_EN defined and TIMEOUT = 4, give gnt but no rvalid.
   -> After 4 WAIT cycles: fault_cause = 10, fault_pc = pc.
   -> Repeat with rst asserted in the 2nd WAIT cycle: FETCH at RESET_PC, and the late rvalid is ignored.
